// File: rtl/ofifo_align_pkg.sv
// ----------------------------------------------------------------------------
// ofifo_align_pkg
//   Shared sizing constants for the systolic array datapath: column count,
//   psum width and FIFO depth. The input FIFO, the array top and the output
//   aligner all use these defaults, so they stay in one place.
//   Also provides a constant-foldable ceil(log2) for pointer sizing.
// ----------------------------------------------------------------------------
package ofifo_align_pkg;

  // Default number of array columns (one FIFO lane per column).
  localparam int OFIFO_COL   = 8;
  // Default psum width per column, bits.
  localparam int PSUM_BW     = 16;
  // Default entries per lane; must be a power of two and >= 2.
  localparam int OFIFO_DEPTH = 64;

  // ceil(log2(value)); returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/ofifo_align_if.sv
// ----------------------------------------------------------------------------
// ofifo_align_if
//   Bundle between the array's per-column valid/psum bus, the controller's
//   row-pop strobe and the output aligner.
//   Signals:
//     wr         per-lane write strobe (array column valid), bit i -> lane i
//     in         lane i data = in[BW*(i+1)-1 : BW*i]
//     rd         pop one aligned row
//     out        head entry of every lane, same slicing as in
//     o_valid    complete row at the head of every lane
//     o_full     at least one lane full
//     o_ready    no lane full
//     o_overflow sticky: a write hit a full lane
//     o_rows     complete rows buffered
//   Modports:
//     master  array/controller side (drives wr/in/rd)
//     slave   the aligner itself
// ----------------------------------------------------------------------------
interface ofifo_align_if
  import ofifo_align_pkg::*;
#(
  parameter int COL   = OFIFO_COL,
  parameter int BW    = PSUM_BW,
  parameter int DEPTH = OFIFO_DEPTH
);

  localparam int AW = clog2(DEPTH);

  logic [COL-1:0]    wr;
  logic [COL*BW-1:0] in;
  logic              rd;
  logic [COL*BW-1:0] out;
  logic              o_valid;
  logic              o_full;
  logic              o_ready;
  logic              o_overflow;
  logic [AW:0]       o_rows;

  modport master (
    output wr, in, rd,
    input  out, o_valid, o_full, o_ready, o_overflow, o_rows
  );

  modport slave (
    input  wr, in, rd,
    output out, o_valid, o_full, o_ready, o_overflow, o_rows
  );

endinterface

// File: rtl/ofifo_align_lane.sv
// ----------------------------------------------------------------------------
// ofifo_lane
//   One column lane of the output aligner: DEPTH x BW storage with wrap-bit
//   pointers, show-ahead head output and empty/full/occupancy status.
//   Ports:
//     clk_i       rising-edge clock
//     rst_ni      asynchronous active-low reset (pointers only)
//     wr_i        write strobe for this lane
//     din_i       write data
//     pop_i       row pop; the top only asserts it when every lane is non-empty
//     dout_o      head entry (zero while the lane is empty)
//     full_o      lane holds DEPTH entries
//     empty_o     lane holds no entries
//     overflow_o  this cycle's write is being dropped (lane full, no pop)
//     occ_o       entries held, 0..DEPTH
// ----------------------------------------------------------------------------
module ofifo_lane
  import ofifo_align_pkg::*;
#(
  parameter int BW    = PSUM_BW,
  parameter int DEPTH = OFIFO_DEPTH
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      wr_i,
  input  logic [BW-1:0]             din_i,
  input  logic                      pop_i,
  output logic [BW-1:0]             dout_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic                      overflow_o,
  output logic [clog2(DEPTH):0]     occ_o
);

  localparam int AW = clog2(DEPTH);

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [BW-1:0] mem_q [DEPTH];
  logic          wr_en;

  // Wrap bit distinguishes full from empty when the index bits match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign occ_o   = wr_ptr_q - rd_ptr_q;

  // A pop on the same edge frees the slot, so a write into a full lane is
  // still accepted when the row is being popped.
  assign wr_en      = wr_i && (!full_o || pop_i);
  assign overflow_o = wr_i && full_o && !pop_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end
  end

  // Empty lanes present zero so the bus is deterministic out of reset.
  assign dout_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/ofifo_align.sv
// ----------------------------------------------------------------------------
// ofifo_align
//   Output-side counterpart of the skewed input FIFO. Psums leave the
//   systolic array column-skewed (column i valid one cycle after column i-1);
//   each column feeds its own lane, and a row becomes poppable once every
//   lane holds at least one entry. The controller/SFU pops one complete,
//   re-aligned row per rd.
//   Ports:
//     clk      rising-edge clock
//     reset_n  asynchronous active-low reset
//     bus      ofifo_align_if slave: wr/in/rd in, out/o_valid/o_full/
//              o_ready/o_overflow/o_rows out
//   All status outputs derive from registered pointers and the registered
//   overflow flag only; wr/rd/in never reach an output combinationally.
// ----------------------------------------------------------------------------
module ofifo_align
  import ofifo_align_pkg::*;
#(
  parameter int COL   = OFIFO_COL,
  parameter int BW    = PSUM_BW,
  parameter int DEPTH = OFIFO_DEPTH
) (
  input  logic         clk,
  input  logic         reset_n,
  ofifo_align_if.slave bus
);

  localparam int AW = clog2(DEPTH);

  logic [COL-1:0]    lane_full;
  logic [COL-1:0]    lane_empty;
  logic [COL-1:0]    ovf_hit;
  logic [AW:0]       occ [COL];
  logic [COL*BW-1:0] head;
  logic              row_valid;
  logic              pop;
  logic [AW:0]       min_occ;
  logic              overflow_q, overflow_d;

  // A row exists only when every lane has something at its head.
  assign row_valid = ~|lane_empty;
  // rd without a complete row is silently ignored.
  assign pop       = bus.rd && row_valid;

  for (genvar gi = 0; gi < COL; gi++) begin : g_lane
    ofifo_lane #(
      .BW    (BW),
      .DEPTH (DEPTH)
    ) u_lane (
      .clk_i      (clk),
      .rst_ni     (reset_n),
      .wr_i       (bus.wr[gi]),
      .din_i      (bus.in[gi*BW +: BW]),
      .pop_i      (pop),
      .dout_o     (head[gi*BW +: BW]),
      .full_o     (lane_full[gi]),
      .empty_o    (lane_empty[gi]),
      .overflow_o (ovf_hit[gi]),
      .occ_o      (occ[gi])
    );
  end

  // Complete rows buffered = the shallowest lane's occupancy.
  always_comb begin
    min_occ = occ[0];
    for (int i = 1; i < COL; i++) begin
      if (occ[i] < min_occ) begin
        min_occ = occ[i];
      end
    end
  end

  // Sticky until reset: any dropped write means a row is corrupted.
  assign overflow_d = overflow_q | (|ovf_hit);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign bus.out        = head;
  assign bus.o_valid    = row_valid;
  assign bus.o_full     = |lane_full;
  assign bus.o_ready    = ~|lane_full;
  assign bus.o_overflow = overflow_q;
  assign bus.o_rows     = min_occ;

endmodule

// File: tb/tb_ofifo_align.sv
module tb_ofifo_align;
  import ofifo_align_pkg::*;

  localparam int COL   = 8;
  localparam int BW    = 16;
  localparam int DEPTH = 64;
  localparam int NROW  = 3 * DEPTH;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ofifo_align_if #(.COL(COL), .BW(BW), .DEPTH(DEPTH)) bus ();

  ofifo_align #(.COL(COL), .BW(BW), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] row_const(input logic [15:0] v);
    logic [127:0] r;
    for (int i = 0; i < COL; i++) r[i*BW +: BW] = v;
    return r;
  endfunction

  function automatic logic [127:0] row_val(input int r);
    logic [127:0] v;
    for (int i = 0; i < COL; i++) v[i*BW +: BW] = 16'(16'h2000 + r * 16 + i);
    return v;
  endfunction

  // Drive one cycle of inputs; returns 1 time unit after the edge.
  task automatic cyc(input logic [7:0] w, input logic [127:0] d, input logic r);
    bus.wr = w;
    bus.in = d;
    bus.rd = r;
    @(posedge clk);
    #1;
    bus.wr = '0;
    bus.rd = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  int           sched [NROW][COL];
  logic [15:0]  lq [COL][$];
  int           nxt [COL];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]   w;
    logic [127:0] d;
    logic [127:0] e;
    logic         r;
    int           popped;
    int           mn;
    logic         ev;
    logic [15:0]  lane0;

    bus.wr = '0;
    bus.in = '0;
    bus.rd = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", bus.o_valid, 0);
    check("rst_ready", bus.o_ready, 1);
    check("rst_full", bus.o_full, 0);
    check("rst_ovf", bus.o_overflow, 0);
    check("rst_rows", bus.o_rows, 0);
    check("rst_out", bus.out, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: reset mid-run with 5 rows buffered
    for (int k = 0; k < 5; k++) cyc(8'hff, row_const(16'(k + 1)), 1'b0);
    check("s1_rows5", bus.o_rows, 5);
    check("s1_valid5", bus.o_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    check("s1_async_valid", bus.o_valid, 0);
    check("s1_async_rows", bus.o_rows, 0);
    check("s1_async_ready", bus.o_ready, 1);
    check("s1_async_ovf", bus.o_overflow, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("s1_rel_valid", bus.o_valid, 0);
    check("s1_rel_rows", bus.o_rows, 0);
    check("s1_rel_ready", bus.o_ready, 1);
    check("s1_rel_ovf", bus.o_overflow, 0);

    // 2: skewed fill of a single row
    e = '0;
    for (int i = 0; i < COL; i++) e[i*BW +: BW] = 16'(16'h0100 + i);
    for (int i = 0; i < COL; i++) begin
      cyc(8'(1 << i), e, 1'b0);
      check("s2_valid_rise", bus.o_valid, (i == COL - 1) ? 1 : 0);
    end
    check("s2_out", bus.out, 128'h0107_0106_0105_0104_0103_0102_0101_0100);
    check("s2_rows", bus.o_rows, 1);
    cyc(8'h00, '0, 1'b1);
    check("s2_pop_valid", bus.o_valid, 0);
    check("s2_pop_rows", bus.o_rows, 0);

    // 3: ten skewed rows, then continuous pops
    for (int c = 0; c < 10 + COL - 1; c++) begin
      w = '0;
      d = '0;
      for (int i = 0; i < COL; i++) begin
        if (c - i >= 0 && c - i < 10) begin
          w[i] = 1'b1;
          d[i*BW +: BW] = 16'(c - i);
        end
      end
      cyc(w, d, 1'b0);
    end
    check("s3_rows10", bus.o_rows, 10);
    for (int k = 0; k < 10; k++) begin
      check("s3_valid", bus.o_valid, 1);
      check("s3_row", bus.out, row_const(16'(k)));
      cyc(8'h00, '0, 1'b1);
    end
    check("s3_drained", bus.o_valid, 0);
    cyc(8'h00, '0, 1'b1);
    cyc(8'h00, '0, 1'b1);
    check("s3_extra_rd_rows", bus.o_rows, 0);
    check("s3_extra_rd_valid", bus.o_valid, 0);
    check("s3_extra_rd_ovf", bus.o_overflow, 0);

    // 4: fill to full, then overflow on lane 3
    for (int k = 0; k < DEPTH; k++) cyc(8'hff, row_val(k), 1'b0);
    check("s4_full", bus.o_full, 1);
    check("s4_ready", bus.o_ready, 0);
    check("s4_rows", bus.o_rows, DEPTH);
    check("s4_ovf_pre", bus.o_overflow, 0);
    cyc(8'h08, row_const(16'hdead), 1'b0);
    check("s4_ovf", bus.o_overflow, 1);
    check("s4_rows_after", bus.o_rows, DEPTH);
    check("s4_head", bus.out, row_val(0));
    for (int k = 0; k < DEPTH; k++) begin
      check("s4_pop_row", bus.out, row_val(k));
      cyc(8'h00, '0, 1'b1);
    end
    check("s4_empty", bus.o_valid, 0);
    check("s4_ovf_sticky", bus.o_overflow, 1);
    check("s4_not_full", bus.o_full, 0);
    do_reset();
    check("s4_ovf_cleared", bus.o_overflow, 0);

    // 5: pop and write on a full lane in the same cycle
    for (int k = 0; k < DEPTH; k++) cyc(8'hff, row_val(k), 1'b0);
    d = '0;
    d[15:0] = 16'hbeef;
    cyc(8'h01, d, 1'b1);
    check("s5_ovf", bus.o_overflow, 0);
    check("s5_full", bus.o_full, 1);
    check("s5_rows", bus.o_rows, DEPTH - 1);
    check("s5_head", bus.out, row_val(1));
    for (int k = 1; k < DEPTH; k++) begin
      check("s5_pop_row", bus.out, row_val(k));
      cyc(8'h00, '0, 1'b1);
    end
    check("s5_valid_end", bus.o_valid, 0);
    check("s5_rows_end", bus.o_rows, 0);
    check("s5_full_end", bus.o_full, 0);
    lane0 = bus.out[15:0];
    check("s5_lane0_left", lane0, 16'hbeef);
    do_reset();

    // 6: wrap with random per-lane skew and a scoreboard
    for (int k = 0; k < NROW; k++) begin
      for (int i = 0; i < COL; i++) begin
        int s;
        s = 2 * k + int'($urandom_range(0, 7));
        if (k > 0 && s <= sched[k-1][i]) s = sched[k-1][i] + 1;
        sched[k][i] = s;
      end
    end
    for (int i = 0; i < COL; i++) nxt[i] = 0;
    popped = 0;
    for (int c = 0; c < 2000 && popped < NROW; c++) begin
      ev = 1'b1;
      mn = DEPTH + 1;
      for (int i = 0; i < COL; i++) begin
        if (lq[i].size() == 0) ev = 1'b0;
        if (lq[i].size() < mn) mn = lq[i].size();
      end
      check("s6_valid", bus.o_valid, ev);
      check("s6_rows", bus.o_rows, mn);
      check("s6_full", bus.o_full, 0);
      if (ev) begin
        e = '0;
        for (int i = 0; i < COL; i++) e[i*BW +: BW] = lq[i][0];
        check("s6_row", bus.out, e);
      end
      r = ev && ($urandom_range(0, 3) != 0);
      w = '0;
      d = '0;
      for (int i = 0; i < COL; i++) begin
        if (nxt[i] < NROW && sched[nxt[i]][i] == c) begin
          w[i] = 1'b1;
          d[i*BW +: BW] = 16'(16'h5a00 ^ (nxt[i] * 8 + i));
        end
      end
      cyc(w, d, r);
      if (r) begin
        for (int i = 0; i < COL; i++) void'(lq[i].pop_front());
        popped++;
      end
      for (int i = 0; i < COL; i++) begin
        if (w[i]) begin
          lq[i].push_back(d[i*BW +: BW]);
          nxt[i]++;
        end
      end
    end
    check("s6_all_popped", popped, NROW);
    check("s6_end_valid", bus.o_valid, 0);
    check("s6_end_ovf", bus.o_overflow, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
